bcd_subtractor_serial: RTL and testbench

- Digit-serial, multi-digit BCD subtractor. Computes A − B − bin, one BCD digit per clock, least significant digit first.
- It is the inverse arithmetic path to the team's BCD adder chain. The adder handles addition; this block handles subtraction and borrow.
- When the result is negative it is returned in ten's-complement form, with the borrow-out flag set.
- A start/busy/done handshake lets a controller sequence it next to the BCD adder datapath.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_subtractor_serial_if.sv | 17 +
 rtl/bcd_digit_sub.sv | 26 ++
 rtl/bcd_subtractor_serial.sv | 138 +++++++++++++
 tb/tb_bcd_subtractor_serial.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state type and digit helper for the BCD
// adder/subtractor datapath.
package bcd_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_subtractor_serial_if.sv
// Start/busy/done handshake and operand/result bus of the serial BCD subtractor.
interface bcd_subtractor_serial_if #(
  parameter int NDIG = 4
);
  logic              start;
  logic [4*NDIG-1:0] a;
  logic [4*NDIG-1:0] b;
  logic              bin;
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] diff;
  logic              bout;
  logic              err;

  modport master (output start, a, b, bin, input busy, done, diff, bout, err);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, err);
endinterface

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtractor cell: d = a - b - bin, corrected by +10 on borrow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] d_o,
  output logic       bout_o
);

  logic [4:0] t_s;

  // Five-bit difference; bit 4 set means the result went negative.
  always_comb begin
    t_s = {1'b0, a_i} - {1'b0, b_i} - {4'd0, bin_i};
    if (t_s[4]) begin
      d_o    = t_s[3:0] + BCD_BASE[3:0];
      bout_o = 1'b1;
    end else begin
      d_o    = t_s[3:0];
      bout_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: A - B - bin, one digit per clock, LSD first.
// Negative results come back in ten's-complement form with bout set.
module bcd_subtractor_serial
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_subtractor_serial_if.slave  bus
);

  localparam int                W        = BCD_W * NDIG;
  localparam int                IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             any_bad_s;
  logic [3:0]       dig_a_s, dig_b_s, dig_d_s;
  logic             dig_bout_s;

  // Flag any non-BCD digit on the incoming operands.
  always_comb begin
    any_bad_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      any_bad_s = any_bad_s
                | ~bcd_digit_valid(bus.a[BCD_W*i +: BCD_W])
                | ~bcd_digit_valid(bus.b[BCD_W*i +: BCD_W]);
    end
  end

  assign dig_a_s = a_q[BCD_W*idx_q +: BCD_W];
  assign dig_b_s = b_q[BCD_W*idx_q +: BCD_W];

  bcd_digit_sub u_digit (
    .a_i    (dig_a_s),
    .b_i    (dig_b_s),
    .bin_i  (borrow_q),
    .d_o    (dig_d_s),
    .bout_o (dig_bout_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.a;
          b_d    = bus.b;
          diff_d = '0;
          idx_d  = '0;
          bout_d = 1'b0;
          if (any_bad_s) begin
            err_d    = 1'b1;
            borrow_d = 1'b0;
            state_d  = DONE;
          end else begin
            err_d    = 1'b0;
            borrow_d = bus.bin;
            state_d  = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        diff_d[BCD_W*idx_q +: BCD_W] = dig_d_s;
        borrow_d                     = dig_bout_s;
        if (idx_q == LAST_IDX) begin
          bout_d  = dig_bout_s;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Scoreboard bench for bcd_subtractor_serial: integer reference model,
// directed corner cases plus randomized operands.
module tb_bcd_subtractor_serial;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         err;
    int           due;
    int           nbusy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_subtractor_serial_if #(.NDIG(NDIG)) bus ();
  bcd_subtractor_serial #(.NDIG(NDIG)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   busy_cnt   = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain decimal arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t    e;
    longint  av = 0, bv = 0, r, m = 1;
    bit      bad = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1;
      av = av * 10 + longint'(a[4*i +: 4]);
      bv = bv * 10 + longint'(b[4*i +: 4]);
      m  = m * 10;
    end
    e.diff = '0;
    e.bout = 1'b0;
    e.err  = bad;
    e.due  = 0;
    if (bad) begin
      e.nbusy = 0;
    end else begin
      e.nbusy = NDIG;
      r = av - bv - longint'(bi);
      if (r < 0) begin
        e.bout = 1'b1;
        r = r + m;
      end
      for (int i = 0; i < NDIG; i++) begin
        e.diff[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
    return e;
  endfunction

  // Monitor: pops expected results whenever the DUT signals done.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt = busy_cnt + 1;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("diff",    64'(bus.diff), 64'(e.diff));
          check("bout",    64'(bus.bout), 64'(e.bout));
          check("err",     64'(bus.err),  64'(e.err));
          check("latency", 64'(cyc),      64'(e.due));
          check("busy_cycles", 64'(busy_cnt), 64'(e.nbusy));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit expect_it);
    exp_t e;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bi;
    bus.start = 1'b1;
    if (expect_it) begin
      e     = model(a, b, bi);
      e.due = cyc + (e.err ? 1 : NDIG + 1);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
    if (allow_bad) v[4*$urandom_range(NDIG-1, 0) +: 4] = 4'($urandom_range(15, 10));
    return v;
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_diff", 64'(bus.diff), 64'd0);
    check("rst_bout", 64'(bus.bout), 64'd0);
    check("rst_err",  64'(bus.err),  64'd0);
    rst = 1'b0;

    issue(16'h5432, 16'h1234, 1'b0, 1'b1); wait_done();
    issue(16'h1000, 16'h0001, 1'b0, 1'b1); wait_done();
    issue(16'h0000, 16'h0001, 1'b0, 1'b1); wait_done();
    issue(16'h0000, 16'h0000, 1'b1, 1'b1); wait_done();
    issue(16'h00A0, 16'h0000, 1'b0, 1'b1); wait_done();
    issue(16'h9999, 16'h0000, 1'b1, 1'b1); wait_done();

    // Start pulsed mid-run with other operands must be ignored.
    issue(16'h9999, 16'h1111, 1'b0, 1'b1);
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h4321; bus.bin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Reset during RUN aborts without a done pulse.
    issue(16'h7777, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_diff", 64'(bus.diff), 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Start in the DONE cycle is dropped; the following IDLE cycle is taken.
    issue(16'h4000, 16'h0123, 1'b0, 1'b1); wait_done();
    bus.a = 16'h1111; bus.b = 16'h2222; bus.bin = 1'b0; bus.start = 1'b1;
    issue(16'h0042, 16'h0917, 1'b1, 1'b1); wait_done();

    for (int k = 0; k < 40; k++) begin
      issue(rand_bcd($urandom_range(7, 0) == 0), rand_bcd(1'b0), 1'($urandom), 1'b1);
      wait_done();
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
